ads1675_acq_ctrl: RTL and testbench

Acquisition controller for the ADS1675 serial interface. It drives the ADC START pin, runs bursts or continuous capture, and detects each DRDY frame. Each frame's 24-bit two's-complement sample is shifted in MSB-first from DOUT and delivered on a valid/ready stream through a small FIFO. It sits between the differential input buffers (single-ended drdy/dout, clocked by the same SCLK as clk) and the DAQ packetiser.

---
 rtl/ads1675_acq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ads1675_acq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads1675_acq_ctrl.sv
// ADS1675 acquisition controller: START control, DRDY framing,
// MSB-first sample capture and a small valid/ready output FIFO.
module ads1675_acq_ctrl #(
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int DISCARD    = 2,
  parameter int TIMEOUT    = 128,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] burst_len,
  input  logic          clr_err,
  input  logic          drdy,
  input  logic          dout,
  output logic          adc_start,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] sample_cnt,
  output logic          overflow,
  output logic          timeout_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int DCW = $clog2(DISCARD + 2);
  localparam int BW  = $clog2(DW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_COMMIT
  } state_t;

  state_t          state;
  logic            drdy_q;
  logic [DW-1:0]   sreg;
  logic [BW-1:0]   bit_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [DCW-1:0]  disc_cnt;
  logic [CW-1:0]   blen_q;

  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;

  logic            drdy_rise;
  logic            keep;
  logic            pop;
  logic            full;
  logic            push_req;
  logic            push_ok;
  logic [CW-1:0]   cnt_inc;

  assign drdy_rise = drdy & ~drdy_q;
  assign keep      = disc_cnt >= DCW'(DISCARD);
  assign m_valid   = count != '0;
  assign pop       = m_valid & m_ready;
  assign full      = count == (AW+1)'(FIFO_DEPTH);
  assign push_req  = (state == S_COMMIT) & ~stop & keep;
  assign push_ok   = push_req & (~full | pop);
  assign cnt_inc   = (&sample_cnt) ? sample_cnt
                                   : sample_cnt + CW'(1);
  assign m_data    = m_valid ? mem[rptr] : '0;
  assign busy      = state != S_IDLE;
  assign adc_start = state != S_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      drdy_q      <= 1'b0;
      sreg        <= '0;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      disc_cnt    <= '0;
      blen_q      <= '0;
      sample_cnt  <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      drdy_q <= drdy;
      done   <= 1'b0;
      if (clr_err) timeout_err <= 1'b0;
      if (stop) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              blen_q     <= burst_len;
              sample_cnt <= '0;
              disc_cnt   <= '0;
              tmo_cnt    <= '0;
              state      <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (drdy_rise) begin
              sreg    <= {{(DW-1){1'b0}}, dout};
              bit_cnt <= BW'(DW - 2);
              state   <= S_SHIFT;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
              if (!clr_err) timeout_err <= 1'b1;
              state <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          S_SHIFT: begin
            sreg <= {sreg[DW-2:0], dout};
            if (bit_cnt == '0) state <= S_COMMIT;
            else bit_cnt <= bit_cnt - BW'(1);
          end
          S_COMMIT: begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
            if (!keep) begin
              disc_cnt <= disc_cnt + DCW'(1);
            end else begin
              // counts dropped samples too so bursts keep a fixed length
              sample_cnt <= cnt_inc;
              if (blen_q != '0 && cnt_inc == blen_q) begin
                done  <= 1'b1;
                state <= S_IDLE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (push_ok && !pop) count <= count + (AW+1)'(1);
      else if (!push_ok && pop) count <= count - (AW+1)'(1);
      if (clr_err) overflow <= 1'b0;
      else if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= sreg;
  end

endmodule

// File: tb/tb_ads1675_acq_ctrl.sv
// Directed + randomized bench for ads1675_acq_ctrl with a
// queue-based expectation model of delivered samples.
module tb_ads1675_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [15:0] burst_len;
  logic        clr_err;
  logic        drdy;
  logic        dout;
  logic        adc_start;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic [15:0] sample_cnt;
  logic        overflow;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];
  logic [23:0] s[5];
  logic [23:0] w;
  int bl;

  ads1675_acq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .burst_len(burst_len), .clr_err(clr_err),
    .drdy(drdy), .dout(dout), .adc_start(adc_start),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // observe handshake/done just before each rising edge
  always @(negedge clk) begin
    #4;
    if (m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back(m_data);
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_got(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [15:0] b);
    burst_len = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // rise of drdy is seen at the next edge together with bit 23
  task automatic drive_frame(input logic [23:0] v, input int last);
    drdy = 1'b1;
    dout = v[23];
    for (int i = 22; i >= last; i--) begin
      @(negedge clk);
      dout = v[i];
      if (i == 20) drdy = 1'b0;
    end
  endtask

  task automatic frame(input logic [23:0] v);
    drive_frame(v, 0);
    gap(25);
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; clr_err = 0;
    drdy = 0; dout = 0; m_ready = 0; burst_len = '0;
    gap(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_adc_start", adc_start, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_timeout", timeout_err, 0);

    // burst of 3 after two settling frames
    m_ready = 1'b1;
    done_cnt = 0;
    pulse_start(16'd3);
    chk("b3_busy", busy, 1);
    chk("b3_adc_start", adc_start, 1);
    frame(24'h000001);
    frame(24'h7FFFFF);
    frame(24'h800000);
    frame(24'hABCDEF);
    frame(24'h123456);
    exp_q = '{24'h800000, 24'hABCDEF, 24'h123456};
    cmp_got("b3_data");
    chk("b3_done_pulses", done_cnt, 1);
    chk("b3_busy_end", busy, 0);
    chk("b3_adc_start_end", adc_start, 0);
    chk("b3_sample_cnt", sample_cnt, 3);
    chk("b3_overflow", overflow, 0);

    // latency from the DRDY edge to m_valid
    pulse_start(16'd1);
    frame(24'($urandom));
    frame(24'($urandom));
    w = 24'($urandom);
    drive_frame(w, 0);
    @(negedge clk);
    chk("lat_valid_t24", m_valid, 0);
    @(negedge clk);
    chk("lat_valid_t25", m_valid, 1);
    chk("lat_data", m_data, w);
    chk("lat_done", done, 1);
    @(negedge clk);
    chk("lat_valid_single", m_valid, 0);
    chk("lat_busy", busy, 0);
    gap(5);
    exp_q.push_back(w);
    cmp_got("lat_stream");

    // backpressure and overflow
    m_ready = 1'b0;
    pulse_start(16'd0);
    frame(24'($urandom));
    frame(24'($urandom));
    for (int i = 0; i < 5; i++) s[i] = 24'($urandom);
    for (int i = 0; i < 4; i++) frame(s[i]);
    chk("bp_no_ovf", overflow, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_head", m_data, s[0]);
    chk("bp_cnt4", sample_cnt, 4);
    frame(s[4]);
    chk("bp_ovf", overflow, 1);
    chk("bp_cnt5", sample_cnt, 5);
    chk("bp_head_hold", m_data, s[0]);
    pulse_stop();
    chk("bp_stop_busy", busy, 0);
    chk("bp_stop_adc", adc_start, 0);
    m_ready = 1'b1;
    gap(8);
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(s[i]);
    cmp_got("bp_drain");
    chk("bp_empty", m_valid, 0);
    pulse_clr();
    chk("bp_clr_ovf", overflow, 0);

    // push and pop in the same cycle while full
    pulse_start(16'd0);
    frame(24'($urandom));
    frame(24'($urandom));
    for (int i = 0; i < 5; i++) s[i] = 24'($urandom);
    for (int i = 0; i < 4; i++) frame(s[i]);
    drive_frame(s[4], 0);
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("pp_no_ovf", overflow, 0);
    chk("pp_valid", m_valid, 1);
    chk("pp_head", m_data, s[1]);
    pulse_stop();
    m_ready = 1'b1;
    gap(8);
    for (int i = 0; i < 5; i++) exp_q.push_back(s[i]);
    cmp_got("pp_drain");
    chk("pp_empty", m_valid, 0);

    // DRDY timeout
    chk("to_pre", timeout_err, 0);
    pulse_start(16'd1);
    gap(127);
    chk("to_t127", timeout_err, 0);
    chk("to_busy_t127", busy, 1);
    gap(1);
    chk("to_t128", timeout_err, 1);
    chk("to_busy_t128", busy, 0);
    chk("to_adc_start", adc_start, 0);
    pulse_start(16'd1);
    chk("to_err_no_block", busy, 1);
    pulse_stop();
    pulse_clr();
    chk("to_clr", timeout_err, 0);
    pulse_start(16'd1);
    gap(127);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("to_clr_prio", timeout_err, 0);
    chk("to_clr_prio_idle", busy, 0);

    // stop while shifting bit 10
    pulse_start(16'd0);
    frame(24'($urandom));
    frame(24'($urandom));
    drive_frame(24'($urandom), 10);
    stop = 1'b1;
    chk("stop_busy_before", busy, 1);
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy_after", busy, 0);
    chk("stop_adc", adc_start, 0);
    gap(30);
    chk("stop_no_push", got_q.size(), 0);
    chk("stop_cnt", sample_cnt, 0);
    chk("stop_valid", m_valid, 0);

    // async reset mid-frame
    m_ready = 1'b0;
    pulse_start(16'd0);
    frame(24'($urandom));
    frame(24'($urandom));
    frame(24'($urandom));
    chk("ar_valid_pre", m_valid, 1);
    chk("ar_cnt_pre", sample_cnt, 1);
    drive_frame(24'($urandom), 12);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid", m_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_adc", adc_start, 0);
    chk("ar_data", m_data, 0);
    chk("ar_cnt", sample_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    drdy = 1'b0;
    @(negedge clk);
    chk("ar_empty_after", m_valid, 0);
    got_q.delete();

    // randomized bursts against the queue model
    m_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bl = $urandom_range(1, 4);
      done_cnt = 0;
      pulse_start(16'(bl));
      for (int f = 0; f < 2 + bl; f++) begin
        w = 24'($urandom);
        if (f >= 2) exp_q.push_back(w);
        drive_frame(w, 0);
        gap($urandom_range(4, 40));
      end
      gap(10);
      cmp_got($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_done", r), done_cnt, 1);
      chk($sformatf("rnd%0d_cnt", r), sample_cnt, 32'(bl));
      chk($sformatf("rnd%0d_busy", r), busy, 0);
      chk($sformatf("rnd%0d_ovf", r), overflow, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
